// File: rtl/rdi_buffer_if.sv
// rdi_buffer_if
//   Bundles the squeeze-side and sampler-side signals of rdi_buffer.
//   master : the producer/consumer environment (SHAKE squeeze + sampler).
//   slave  : the buffer itself.
//
//   Signals
//     flush      master->slave  synchronous clear of all buffered data
//     in_valid   master->slave  in_data holds a squeeze word
//     in_ready   slave->master  buffer takes in_data this cycle
//     in_data    master->slave  64-bit squeeze word, little-endian bytes
//     rdi_ready  master->slave  pop request, one pulse per consumed word
//     rdi_data   slave->master  128-bit head word (zero when empty)
//     rdi_valid  slave->master  head word present
//     level      slave->master  complete 128-bit words held
//     underflow  slave->master  sticky: pop requested while empty
//
//   Handshake: a squeeze word transfers on a rising edge where
//   in_valid && in_ready are both high; in_data must hold while in_valid is
//   high and in_ready is low. A head word is consumed on an edge where
//   rdi_ready && rdi_valid are both high; rdi_ready with rdi_valid low
//   consumes nothing and raises underflow.
interface rdi_buffer_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH + 1);

   logic           flush;
   logic           in_valid;
   logic           in_ready;
   logic [63:0]    in_data;
   logic           rdi_ready;
   logic [127:0]   rdi_data;
   logic           rdi_valid;
   logic [LW-1:0]  level;
   logic           underflow;

   modport master (
      output flush, in_valid, in_data, rdi_ready,
      input  in_ready, rdi_data, rdi_valid, level, underflow
   );

   modport slave (
      input  flush, in_valid, in_data, rdi_ready,
      output in_ready, rdi_data, rdi_valid, level, underflow
   );
endinterface

// File: rtl/rdi_buffer.sv
// rdi_buffer
//   Random-data input buffer between the SHAKE squeeze output and the
//   binomial sampler. Pairs of 64-bit squeeze words are packed into 128-bit
//   words (first word in the low half) and queued in a DEPTH-entry FIFO whose
//   head is presented combinationally on rdi_data.
//
//   Ports
//     clk       rising-edge clock
//     rst       asynchronous active-high reset
//     bus       rdi_buffer_if.slave (flush, squeeze input, sampler output,
//               level, underflow)
//     dbg_half  packer state: 1 when a low half is waiting in staging
//     dbg_wp    FIFO write pointer
//     dbg_rp    FIFO read pointer
//
//   DEPTH must be a power of two and at least 2 so the pointers wrap
//   naturally modulo DEPTH.
module rdi_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   rdi_buffer_if.slave               bus,
   output logic                      dbg_half,
   output logic [$clog2(DEPTH)-1:0]  dbg_wp,
   output logic [$clog2(DEPTH)-1:0]  dbg_rp
);
   localparam int             PW   = $clog2(DEPTH);
   localparam int             LW   = $clog2(DEPTH + 1);
   localparam logic [LW-1:0]  FULL = LW'(DEPTH);

   typedef enum logic {
      EMPTY_HALF = 1'b0,
      LOW_HELD   = 1'b1
   } half_t;

   half_t          half_q, half_n;
   logic [63:0]    staging_q, staging_n;
   logic [PW-1:0]  wp_q, wp_n;
   logic [PW-1:0]  rp_q, rp_n;
   logic [LW-1:0]  level_q, level_n;
   logic           underflow_q, underflow_n;
   logic           in_ready_q, in_ready_n;
   logic [127:0]   mem [DEPTH];

   logic           accept;
   logic           push;
   logic           pop;

   assign accept = bus.in_valid && in_ready_q;
   // A flush discards any push or pop presented in the same cycle.
   assign push   = accept && (half_q == LOW_HELD) && !bus.flush;
   assign pop    = bus.rdi_ready && (level_q != '0) && !bus.flush;

   always_comb begin
      half_n      = half_q;
      staging_n   = staging_q;
      wp_n        = wp_q;
      rp_n        = rp_q;
      level_n     = level_q;
      underflow_n = underflow_q;

      if (bus.flush) begin
         half_n      = EMPTY_HALF;
         wp_n        = '0;
         rp_n        = '0;
         level_n     = '0;
         underflow_n = 1'b0;
      end else begin
         if (accept) begin
            if (half_q == EMPTY_HALF) begin
               staging_n = bus.in_data;
               half_n    = LOW_HELD;
            end else begin
               half_n    = EMPTY_HALF;
            end
         end

         if (push) wp_n = wp_q + PW'(1);
         if (pop)  rp_n = rp_q + PW'(1);

         if (push && !pop)
            level_n = level_q + LW'(1);
         else if (pop && !push)
            level_n = level_q - LW'(1);

         if (bus.rdi_ready && (level_q == '0))
            underflow_n = 1'b1;
      end

      // The upper half needs a free slot judged on the registered level, so
      // the ready flag depends only on state and can be registered with it.
      // A pop in the same cycle as a full-FIFO upper half does not help;
      // that word waits for the next cycle.
      in_ready_n = !((half_n == LOW_HELD) && (level_n == FULL));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half_q      <= EMPTY_HALF;
         staging_q   <= '0;
         wp_q        <= '0;
         rp_q        <= '0;
         level_q     <= '0;
         underflow_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         half_q      <= half_n;
         staging_q   <= staging_n;
         wp_q        <= wp_n;
         rp_q        <= rp_n;
         level_q     <= level_n;
         underflow_q <= underflow_n;
         in_ready_q  <= in_ready_n;
      end
   end

   // Storage carries no reset: entries are only observable while level
   // counts them, and level clears on rst/flush.
   always_ff @(posedge clk) begin
      if (push)
         mem[wp_q] <= {bus.in_data, staging_q};
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.rdi_valid = (level_q != '0);
   assign bus.rdi_data  = (level_q != '0) ? mem[rp_q] : '0;
   assign bus.level     = level_q;
   assign bus.underflow = underflow_q;

   assign dbg_half = (half_q == LOW_HELD);
   assign dbg_wp   = wp_q;
   assign dbg_rp   = rp_q;
endmodule

// File: tb/tb_rdi_buffer.sv
// tb_rdi_buffer
//   Self-checking bench for rdi_buffer (DEPTH=4). A queue-based reference
//   model tracks the packed words, the pending low half and the sticky
//   underflow flag; every cycle the DUT outputs are compared against it,
//   and directed scenarios add constant checks on top.
module tb_rdi_buffer;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH + 1);
   localparam int PW    = $clog2(DEPTH);

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           dbg_half;
   logic [PW-1:0]  dbg_wp;
   logic [PW-1:0]  dbg_rp;

   int tests_run    = 0;
   int tests_failed = 0;

   rdi_buffer_if #(.DEPTH(DEPTH)) bus ();

   rdi_buffer #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dbg_half (dbg_half),
      .dbg_wp   (dbg_wp),
      .dbg_rp   (dbg_rp)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [127:0] exp_q[$];
   logic         m_half;
   logic [63:0]  m_stg;
   logic         m_udf;
   int           m_push;
   int           m_pop;

   task automatic model_reset();
      exp_q.delete();
      m_half = 1'b0;
      m_stg  = '0;
      m_udf  = 1'b0;
      m_push = 0;
      m_pop  = 0;
   endtask

   function automatic bit exp_in_ready();
      return !(m_half && (exp_q.size() == DEPTH));
   endfunction

   // Applies the inputs present at this edge to the model.
   task automatic model_step();
      bit acc;
      if (rst || bus.flush) begin
         model_reset();
      end else begin
         acc = bus.in_valid && exp_in_ready();
         if (bus.rdi_ready && exp_q.size() == 0) m_udf = 1'b1;
         if (bus.rdi_ready && exp_q.size() != 0) begin
            exp_q.delete(0);
            m_pop++;
         end
         if (acc) begin
            if (!m_half) begin
               m_stg  = bus.in_data;
               m_half = 1'b1;
            end else begin
               exp_q.push_back({bus.in_data, m_stg});
               m_push++;
               m_half = 1'b0;
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   task automatic compare_state();
      check("in_ready",  128'(bus.in_ready),  128'(exp_in_ready()));
      check("rdi_valid", 128'(bus.rdi_valid), 128'(exp_q.size() != 0));
      check("level",     128'(bus.level),     128'(exp_q.size()));
      check("rdi_data",  bus.rdi_data,        (exp_q.size() != 0) ? exp_q[0] : 128'h0);
      check("underflow", 128'(bus.underflow), 128'(m_udf));
      check("half",      128'(dbg_half),      128'(m_half));
      check("wp",        128'(dbg_wp),        128'(m_push % DEPTH));
      check("rp",        128'(dbg_rp),        128'(m_pop % DEPTH));
   endtask

   // ---------------- driver tasks ----------------
   // Compares the pre-edge outputs, advances the model with the current
   // inputs, then returns 1 time unit after the rising edge.
   task automatic cycle();
      @(negedge clk);
      compare_state();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.rdi_ready = 1'b0;
   endtask

   task automatic push_word(input logic [63:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      cycle();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bus.rdi_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2 && exp_q.size() != 0; i++) cycle();
      bus.rdi_ready = 1'b0;
   endtask

   function automatic logic [63:0] fw(input int i);
      return 64'hF000_0000_0000_0000 + 64'(i);
   endfunction

   function automatic logic [63:0] squeeze_word(input int j);
      logic [63:0] k;
      k = 64'(j / 2);
      return (j % 2 == 0) ? k : (k | 64'hA5A5_0000_0000_0000);
   endfunction

   function automatic logic [127:0] stream_word(input int k);
      return {squeeze_word(2 * k + 1), squeeze_word(2 * k)};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [127:0] pair;
      idle_inputs();
      model_reset();

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  128'(bus.in_ready),  128'(1));
      check("rst_rdi_valid", 128'(bus.rdi_valid), 128'(0));
      check("rst_rdi_data",  bus.rdi_data,        128'h0);
      check("rst_level",     128'(bus.level),     128'(0));
      check("rst_underflow", 128'(bus.underflow), 128'(0));
      rst = 1'b0;

      // Reset and single word
      bus.in_valid = 1'b1;
      bus.in_data  = 64'h0706050403020100;
      cycle();
      bus.in_data  = 64'h0F0E0D0C0B0A0908;
      cycle();
      bus.in_valid = 1'b0;
      check("single_valid", 128'(bus.rdi_valid), 128'(1));
      check("single_level", 128'(bus.level),     128'(1));
      check("single_data",  bus.rdi_data, 128'h0F0E0D0C0B0A09080706050403020100);
      drain();

      // Fill to full, then the 10th word waits for a pop
      bus.in_valid = 1'b1;
      for (int i = 0; i < 2 * DEPTH + 1; i++) begin
         bus.in_data = fw(i);
         cycle();
      end
      check("fill_level", 128'(bus.level), 128'(DEPTH));
      check("fill_half",  128'(dbg_half),  128'(1));
      bus.in_data = fw(9);
      check("fill_in_ready_full", 128'(bus.in_ready), 128'(0));
      cycle();
      bus.rdi_ready = 1'b1;
      check("fill_head", bus.rdi_data, {fw(1), fw(0)});
      check("fill_no_pushthrough", 128'(bus.in_ready), 128'(0));
      cycle();
      bus.rdi_ready = 1'b0;
      check("fill_reenable", 128'(bus.in_ready), 128'(1));
      cycle();
      bus.in_valid = 1'b0;
      check("fill_level_back", 128'(bus.level), 128'(DEPTH));
      check("fill_head2", bus.rdi_data, {fw(3), fw(2)});
      drain();

      // Wrap-around stream: 128 squeeze words, each head popped 3 cycles in
      begin
         int sent = 0, popped = 0, age = 0, wraps = 0;
         bit was_valid, pop_now;
         logic [PW-1:0] last_rp;
         for (int c = 0; c < 3000 && popped < 64; c++) begin
            bus.in_valid  = (sent < 128) && ($urandom_range(0, 3) != 0);
            bus.in_data   = squeeze_word(sent);
            pop_now       = (exp_q.size() != 0) && (age == 3);
            bus.rdi_ready = pop_now;
            if (pop_now) begin
               check("stream_order", bus.rdi_data, stream_word(popped));
               popped++;
            end
            if (bus.in_valid && exp_in_ready()) sent++;
            was_valid = (exp_q.size() != 0);
            last_rp   = dbg_rp;
            cycle();
            if (last_rp == PW'(DEPTH - 1) && dbg_rp == '0) wraps++;
            if (pop_now || !was_valid) age = 0;
            else age++;
         end
         idle_inputs();
         check("stream_popped",    128'(popped),        128'(64));
         check("stream_sent",      128'(sent),          128'(128));
         check("stream_wraps",     128'(wraps),         128'(16));
         check("stream_underflow", 128'(bus.underflow), 128'(0));
      end

      // Simultaneous push and pop at level 2
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.in_data = fw(20 + i);
         cycle();
      end
      check("sim_pre_level", 128'(bus.level), 128'(2));
      bus.in_data   = fw(25);
      bus.rdi_ready = 1'b1;
      cycle();
      bus.in_valid  = 1'b0;
      check("sim_level", 128'(bus.level), 128'(2));
      check("sim_head",  bus.rdi_data, {fw(23), fw(22)});
      cycle();
      bus.rdi_ready = 1'b0;
      check("sim_tail",  bus.rdi_data, {fw(25), fw(24)});
      drain();

      // Underflow
      bus.rdi_ready = 1'b1;
      cycle();
      bus.rdi_ready = 1'b0;
      check("udf_flag",  128'(bus.underflow), 128'(1));
      check("udf_data",  bus.rdi_data,        128'h0);
      check("udf_level", 128'(bus.level),     128'(0));
      push_word(64'h1111);
      push_word(64'h2222);
      check("udf_sticky", 128'(bus.underflow), 128'(1));
      check("udf_level1", 128'(bus.level),     128'(1));
      bus.flush = 1'b1;
      cycle();
      bus.flush = 1'b0;
      check("udf_flush", 128'(bus.underflow), 128'(0));
      check("udf_flush_level", 128'(bus.level), 128'(0));

      // Flush mid-pack with half=1, level=3
      bus.in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         bus.in_data = fw(40 + i);
         cycle();
      end
      check("fl_pre_level", 128'(bus.level), 128'(3));
      check("fl_pre_half",  128'(dbg_half),  128'(1));
      bus.flush     = 1'b1;
      bus.rdi_ready = 1'b1;
      bus.in_data   = fw(47);
      cycle();
      idle_inputs();
      check("fl_level",    128'(bus.level),     128'(0));
      check("fl_valid",    128'(bus.rdi_valid), 128'(0));
      check("fl_in_ready", 128'(bus.in_ready),  128'(1));
      push_word(64'hAAAA_0000_0000_0001);
      push_word(64'hBBBB_0000_0000_0002);
      pair = {64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
      check("fl_new_head", bus.rdi_data, pair);
      drain();

      // Random traffic with occasional flush and one asynchronous reset
      for (int c = 0; c < 400; c++) begin
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.in_data   = {$urandom, $urandom};
         bus.rdi_ready = ($urandom_range(0, 2) == 0);
         bus.flush     = ($urandom_range(0, 49) == 0);
         if (c == 200) begin
            rst = 1'b1;
            #1;
            check("arst_level", 128'(bus.level),     128'(0));
            check("arst_valid", 128'(bus.rdi_valid), 128'(0));
            check("arst_ready", 128'(bus.in_ready),  128'(1));
            model_reset();
            cycle();
            rst = 1'b0;
         end else begin
            cycle();
         end
      end
      idle_inputs();
      cycle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
